// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one adder among NREQ requesters and returns
// each tagged sum on a single valid/ready channel. ADDER_ARB_CARRY_EN adds rsp_cout.

module adder #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s
);
    assign s = a + b;
endmodule

module adder_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_sum,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                 busy
`ifdef ADDER_ARB_CARRY_EN
    ,
    output logic                 rsp_cout
`endif
);
    localparam int IDW = $clog2(NREQ);
`ifdef ADDER_ARB_CARRY_EN
    localparam int AW = N + 1;
`else
    localparam int AW = N;
`endif

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic [IDW-1:0]  id_reg;
    logic [N-1:0]    a_reg, b_reg;
    logic [N-1:0]    rsp_sum_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [AW-1:0]   sum_full;
    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];
    logic [IDW-1:0]  gnt_idx;
    logic            any_valid;
    logic            grant_en;
    logic            accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_arr[gi]     = req_a[gi*N +: N];
            assign b_arr[gi]     = req_b[gi*N +: N];
            assign req_ready[gi] = accept && (gnt_idx == IDW'(gi));
        end
    endgenerate

    assign any_valid = |req_valid;
    assign accept    = grant_en && any_valid;

    // First valid requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        logic found;
        int   cand;
        found   = 1'b0;
        cand    = 0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_reg) + k) % NREQ;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end

    assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid) state_next = CALC;
            CALC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = any_valid ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grants are only offered when the response slot is free or being freed.
    always_comb begin
        rsp_valid = (state_reg == RESP);
        busy      = (state_reg != IDLE);
        grant_en  = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    end

    adder #(.n(AW)) u_adder (
        .a (AW'(a_reg)),
        .b (AW'(b_reg)),
        .s (sum_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg     <= '0;
            id_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            rsp_sum_reg <= '0;
            rsp_id_reg  <= '0;
        end else begin
            if (accept) begin
                a_reg   <= a_arr[gnt_idx];
                b_reg   <= b_arr[gnt_idx];
                id_reg  <= gnt_idx;
                ptr_reg <= ptr_next;
            end
            if (state_reg == CALC) begin
                rsp_sum_reg <= sum_full[N-1:0];
                rsp_id_reg  <= id_reg;
            end
        end
    end

    assign rsp_sum = rsp_sum_reg;
    assign rsp_id  = rsp_id_reg;

`ifdef ADDER_ARB_CARRY_EN
    logic rsp_cout_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cout_reg <= 1'b0;
        end else if (state_reg == CALC) begin
            rsp_cout_reg <= sum_full[N];
        end
    end
    assign rsp_cout = rsp_cout_reg;
`endif

endmodule
